uart_rx_fifo: RTL

Receive FIFO stage directly downstream of the UART receiver. It captures each received character and its per-character error flags (pe, fe, bi) on the receiver's single-cycle push strobe, and buffers them for the register/bus interface. It generates the 16550-style line-status inputs: data ready, overrun, FIFO error, trigger-level reached and character timeout. When disabled it runs as a 1-entry holding register (non-FIFO mode).

---
 rtl/uart_rx_fifo.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: buffers characters with their pe/fe/bi flags
// and derives the 16550 line-status inputs (data ready, overrun, FIFO error, trigger, timeout).
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int TO_PULSES = 640
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [1:0]    trig_lvl,
  input  logic          baud_pulse,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pe_in,
  input  logic          fe_in,
  input  logic          bi_in,
  input  logic          pop,
  input  logic          lsr_rd,
  output logic [7:0]    dout,
  output logic          dout_pe,
  output logic          dout_fe,
  output logic          dout_bi,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          fifo_err,
  output logic          trig,
  output logic          timeout
);

  localparam int TW = $clog2(TO_PULSES + 1);
  localparam int CW = ((AW + 1) > 5) ? (AW + 1) : 5;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW + 1)'(1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TO_PULSES);

  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_err_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_overrun;
  logic          r_en_q;

  logic          w_empty;
  logic          w_full;
  logic          w_flush;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic          w_ovr_set;
  logic          w_overwrite;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_idx;
  logic [10:0]   w_head;
  logic [AW:0]   w_eff_depth;
  logic          w_err_inc;
  logic          w_err_dec;
  logic          w_to_clr;
  logic [CW-1:0] w_thr;

  // Transaction qualification: a change of en flushes exactly like clr.
  always_comb begin
    w_empty     = (r_count == '0);
    w_eff_depth = en ? DEPTH_C : ONE_C;
    w_full      = (r_count == w_eff_depth);
    w_flush     = clr | (en != r_en_q);
    w_head      = r_mem[r_rd_ptr];
    w_pop_ok    = pop & ~w_empty & ~w_flush;
    w_push_ok   = push & (~w_full | w_pop_ok) & ~w_flush;
    w_ovr_set   = push & w_full & ~w_pop_ok & ~w_flush;
    // Non-FIFO mode replaces the held character instead of dropping the new one.
    w_overwrite = w_ovr_set & ~en;
    w_wr_en     = w_push_ok | w_overwrite;
    w_wr_idx    = w_overwrite ? r_rd_ptr : r_wr_ptr;
    w_err_inc   = w_wr_en & (pe_in | fe_in | bi_in);
    w_err_dec   = (w_pop_ok | w_overwrite) & (|w_head[10:8]);
    w_to_clr    = w_push_ok | w_pop_ok | w_flush | w_empty | ~en;
  end

  // Trigger threshold decode.
  always_comb begin
    w_thr = CW'(5'd1);
    case (trig_lvl)
      2'b00:   w_thr = CW'(5'd1);
      2'b01:   w_thr = CW'(5'd4);
      2'b10:   w_thr = CW'(5'd8);
      2'b11:   w_thr = CW'(5'd14);
      default: w_thr = CW'(5'd1);
    endcase
  end

  // Storage array; contents need no reset since outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= {bi_in, fe_in, pe_in, din};
    end
  end

  // Pointers, occupancy and error-entry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
      case ({w_err_inc, w_err_dec})
        2'b10:   r_err_cnt <= r_err_cnt + ONE_C;
        2'b01:   r_err_cnt <= r_err_cnt - ONE_C;
        default: r_err_cnt <= r_err_cnt;
      endcase
    end
  end

  // Sticky overrun; a new overrun beats a simultaneous LSR read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (lsr_rd) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  // Registered copy of en for mode-change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_q <= 1'b0;
    end else begin
      r_en_q <= en;
    end
  end

  // Character timeout counter, saturating at TO_PULSES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_to_clr) begin
      r_to_cnt <= '0;
    end else if (baud_pulse && (r_to_cnt != TO_MAX)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  // Status and head-of-queue outputs.
  always_comb begin
    empty    = w_empty;
    full     = w_full;
    count    = r_count;
    overrun  = r_overrun;
    fifo_err = (r_err_cnt != '0);
    timeout  = (r_to_cnt == TO_MAX);
    trig     = en ? (CW'(r_count) >= w_thr) : ~w_empty;
    dout     = w_empty ? 8'h00 : w_head[7:0];
    dout_pe  = w_empty ? 1'b0  : w_head[8];
    dout_fe  = w_empty ? 1'b0  : w_head[9];
    dout_bi  = w_empty ? 1'b0  : w_head[10];
  end

endmodule
